// File: rtl/pbch_eq_scheduler_pkg.sv
// Shared constants and FSM state encoding for the PBCH equalizer scheduler.
package pbch_eq_scheduler_pkg;
   localparam int PBCH_NUM_RE = 432;
   localparam int PBCH_RX_WL  = 12;
   localparam int PBCH_CH_WL  = 8;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} sched_state_e;
endpackage

// File: rtl/pbch_re_addr_gen.sv
// Issue-side address generator: walks RE indices 0..num-1, stalls on hold,
// and derives the channel-estimate address shared by 2^CH_SHARE_LOG2 REs.
module pbch_re_addr_gen #(
   parameter int ADDR_W        = 9,
   parameter int CH_SHARE_LOG2 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              run,
   input  logic              hold,
   input  logic [ADDR_W-1:0] num,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rx_addr,
   output logic [ADDR_W-1:0] ch_addr,
   output logic              last
);
   logic [ADDR_W-1:0] issue_q, issue_d;

   always_comb begin
      rd_en   = run && !hold;
      rx_addr = issue_q;
      ch_addr = issue_q >> CH_SHARE_LOG2;
      last    = rd_en && (issue_q == num - ADDR_W'(1));
      issue_d = issue_q;
      if (clr) begin
         issue_d = '0;
      end else if (rd_en) begin
         issue_d = issue_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_q <= '0;
      end else begin
         issue_q <= issue_d;
      end
   end
endmodule

// File: rtl/pbch_eq_scheduler.sv
// PBCH equalizer sequencer for one SSB: fetches RE/channel pairs, strobes them
// into the equalizer, counts equalizer output beats and pulses done at the end.
module pbch_eq_scheduler
   import pbch_eq_scheduler_pkg::*;
#(
   parameter int RX_WL         = PBCH_RX_WL,
   parameter int CH_WL         = PBCH_CH_WL,
   parameter int ADDR_W        = 9,
   parameter int CH_SHARE_LOG2 = 0,
   parameter int MAX_RE        = PBCH_NUM_RE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_W-1:0]       num_re,
   input  logic                    hold,
   output logic                    rx_rd_en,
   output logic [ADDR_W-1:0]       rx_rd_addr,
   input  logic signed [RX_WL-1:0] rx_rd_i,
   input  logic signed [RX_WL-1:0] rx_rd_q,
   output logic                    ch_rd_en,
   output logic [ADDR_W-1:0]       ch_rd_addr,
   input  logic signed [CH_WL-1:0] ch_rd_i,
   input  logic signed [CH_WL-1:0] ch_rd_q,
   output logic signed [RX_WL-1:0] eq_rx_i,
   output logic signed [RX_WL-1:0] eq_rx_q,
   output logic signed [CH_WL-1:0] eq_ch_i,
   output logic signed [CH_WL-1:0] eq_ch_q,
   output logic                    eq_in_valid,
   input  logic                    eq_out_valid,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       re_count
);
   localparam logic [ADDR_W-1:0] MAX_RE_W = ADDR_W'(MAX_RE);

   // Zero or oversized run lengths fall back to a full PBCH.
   function automatic logic [ADDR_W-1:0] clamp_num(input logic [ADDR_W-1:0] n);
      return (n == '0 || n > MAX_RE_W) ? MAX_RE_W : n;
   endfunction

   function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] c,
                                                 input logic [ADDR_W-1:0] lim);
      return (c >= lim) ? lim : c + ADDR_W'(1);
   endfunction

   sched_state_e            state_q, state_d;
   logic [ADDR_W-1:0]       num_q, num_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pend_q, pend_d;
   logic                    eq_vld_q, eq_vld_d;
   logic signed [RX_WL-1:0] eq_rx_i_q, eq_rx_i_d, eq_rx_q_q, eq_rx_q_d;
   logic signed [CH_WL-1:0] eq_ch_i_q, eq_ch_i_d, eq_ch_q_q, eq_ch_q_d;
   logic                    rd_en, last_issue, addr_clr;

   pbch_re_addr_gen #(
      .ADDR_W       (ADDR_W),
      .CH_SHARE_LOG2(CH_SHARE_LOG2)
   ) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .clr    (addr_clr),
      .run    (state_q == FETCH),
      .hold   (hold),
      .num    (num_q),
      .rd_en  (rd_en),
      .rx_addr(rx_rd_addr),
      .ch_addr(ch_rd_addr),
      .last   (last_issue)
   );

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      addr_clr  = 1'b0;
      // Read-pending pipe aligns the strobe with the 1-cycle memory latency.
      pend_d    = rd_en;
      eq_vld_d  = pend_q;
      eq_rx_i_d = pend_q ? rx_rd_i : eq_rx_i_q;
      eq_rx_q_d = pend_q ? rx_rd_q : eq_rx_q_q;
      eq_ch_i_d = pend_q ? ch_rd_i : eq_ch_i_q;
      eq_ch_q_d = pend_q ? ch_rd_q : eq_ch_q_q;
      if (busy_q && eq_out_valid) begin
         cnt_d = sat_inc(cnt_q, num_q);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d    = clamp_num(num_re);
               cnt_d    = '0;
               addr_clr = 1'b1;
               busy_d   = 1'b1;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            // Done is registered, so it is judged on the count being written now.
            if (cnt_d == num_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d  = IDLE;
         cnt_d    = '0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         pend_d   = 1'b0;
         eq_vld_d = 1'b0;
         addr_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         num_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pend_q    <= 1'b0;
         eq_vld_q  <= 1'b0;
         eq_rx_i_q <= '0;
         eq_rx_q_q <= '0;
         eq_ch_i_q <= '0;
         eq_ch_q_q <= '0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         eq_vld_q  <= eq_vld_d;
         eq_rx_i_q <= eq_rx_i_d;
         eq_rx_q_q <= eq_rx_q_d;
         eq_ch_i_q <= eq_ch_i_d;
         eq_ch_q_q <= eq_ch_q_d;
      end
   end

   assign rx_rd_en    = rd_en;
   assign ch_rd_en    = rd_en;
   assign eq_rx_i     = eq_rx_i_q;
   assign eq_rx_q     = eq_rx_q_q;
   assign eq_ch_i     = eq_ch_i_q;
   assign eq_ch_q     = eq_ch_q_q;
   assign eq_in_valid = eq_vld_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign re_count    = cnt_q;
endmodule

// File: tb/tb_pbch_eq_scheduler.sv
// Scoreboard bench for pbch_eq_scheduler: stimulus queues expected reads, strobes
// and done pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_pbch_eq_scheduler;
   localparam int AW = 9;
   localparam int RW = 12;
   localparam int CW = 8;

   typedef struct packed {int rel; int addr;} ent_t;
   typedef struct packed {int rel; int rx; int ch;} ent2_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, start2 = 1'b0, abort = 1'b0, hold = 1'b0, stray = 1'b0;
   logic [AW-1:0] num_re = '0;

   logic                 rx_rd_en, ch_rd_en, eq_in_valid, eq_out_valid, busy, done;
   logic [AW-1:0]        rx_rd_addr, ch_rd_addr, re_count;
   logic signed [RW-1:0] rx_rd_i = '0, rx_rd_q = '0, eq_rx_i, eq_rx_q;
   logic signed [CW-1:0] ch_rd_i = '0, ch_rd_q = '0, eq_ch_i, eq_ch_q;
   logic                 eqm_q = 1'b0;

   logic                 rx_rd_en2, ch_rd_en2, eq_in_valid2, eq_out_valid2, busy2, done2;
   logic [AW-1:0]        rx_rd_addr2, ch_rd_addr2, re_count2;
   logic signed [RW-1:0] z_rx = '0, eq_rx_i2, eq_rx_q2;
   logic signed [CW-1:0] z_ch = '0, eq_ch_i2, eq_ch_q2;
   logic                 eqm2_q = 1'b0;

   int cyc = 0, t0 = 0, total = 0, bad = 0;
   ent_t  q_rd[$], q_in[$], q_done[$];
   ent2_t q_rd2[$];

   always #5 clk = ~clk;

   pbch_eq_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_re(num_re), .hold(hold),
      .rx_rd_en(rx_rd_en), .rx_rd_addr(rx_rd_addr), .rx_rd_i(rx_rd_i), .rx_rd_q(rx_rd_q),
      .ch_rd_en(ch_rd_en), .ch_rd_addr(ch_rd_addr), .ch_rd_i(ch_rd_i), .ch_rd_q(ch_rd_q),
      .eq_rx_i(eq_rx_i), .eq_rx_q(eq_rx_q), .eq_ch_i(eq_ch_i), .eq_ch_q(eq_ch_q),
      .eq_in_valid(eq_in_valid), .eq_out_valid(eq_out_valid), .busy(busy), .done(done),
      .re_count(re_count)
   );

   pbch_eq_scheduler #(.CH_SHARE_LOG2(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort), .num_re(num_re), .hold(hold),
      .rx_rd_en(rx_rd_en2), .rx_rd_addr(rx_rd_addr2), .rx_rd_i(z_rx), .rx_rd_q(z_rx),
      .ch_rd_en(ch_rd_en2), .ch_rd_addr(ch_rd_addr2), .ch_rd_i(z_ch), .ch_rd_q(z_ch),
      .eq_rx_i(eq_rx_i2), .eq_rx_q(eq_rx_q2), .eq_ch_i(eq_ch_i2), .eq_ch_q(eq_ch_q2),
      .eq_in_valid(eq_in_valid2), .eq_out_valid(eq_out_valid2), .busy(busy2), .done(done2),
      .re_count(re_count2)
   );

   function automatic logic signed [RW-1:0] rxi_f(input int a); return RW'(a * 7 + 3);  endfunction
   function automatic logic signed [RW-1:0] rxq_f(input int a); return RW'(2047 - a * 3); endfunction
   function automatic logic signed [CW-1:0] chi_f(input int a); return CW'(a * 5 + 1);  endfunction
   function automatic logic signed [CW-1:0] chq_f(input int a); return CW'(-a - 2);     endfunction

   // Memories with 1-cycle read latency and a 1-cycle equalizer.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_rd_en) begin
         rx_rd_i <= rxi_f(int'(rx_rd_addr));
         rx_rd_q <= rxq_f(int'(rx_rd_addr));
      end
      if (ch_rd_en) begin
         ch_rd_i <= chi_f(int'(ch_rd_addr));
         ch_rd_q <= chq_f(int'(ch_rd_addr));
      end
      eqm_q  <= eq_in_valid;
      eqm2_q <= eq_in_valid2;
   end
   assign eq_out_valid  = eqm_q | stray;
   assign eq_out_valid2 = eqm2_q;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      ent_t  e;
      ent2_t e2;
      if (!rst) begin
         if (rx_rd_en || ch_rd_en) begin
            if (q_rd.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               e = q_rd.pop_front();
               chk("rd_cycle", cyc - t0, e.rel);
               chk("rx_rd_addr", int'(rx_rd_addr), e.addr);
               chk("ch_rd_addr", int'(ch_rd_addr), e.addr);
               chk("rd_en_pair", int'(rx_rd_en & ch_rd_en), 1);
            end
         end
         if (eq_in_valid) begin
            if (q_in.size() == 0) chk("unexpected_in_valid", 1, 0);
            else begin
               e = q_in.pop_front();
               chk("in_valid_cycle", cyc - t0, e.rel);
               chk("eq_rx_i", int'(eq_rx_i), int'(rxi_f(e.addr)));
               chk("eq_rx_q", int'(eq_rx_q), int'(rxq_f(e.addr)));
               chk("eq_ch_i", int'(eq_ch_i), int'(chi_f(e.addr)));
               chk("eq_ch_q", int'(eq_ch_q), int'(chq_f(e.addr)));
            end
         end
         if (done) begin
            if (q_done.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q_done.pop_front();
               chk("done_cycle", cyc - t0, e.rel);
               chk("done_re_count", int'(re_count), e.addr);
               chk("busy_at_done", int'(busy), 0);
            end
         end
         if (rx_rd_en2) begin
            if (q_rd2.size() == 0) chk("unexpected_read_share", 1, 0);
            else begin
               e2 = q_rd2.pop_front();
               chk("share_rd_cycle", cyc - t0, e2.rel);
               chk("share_rx_addr", int'(rx_rd_addr2), e2.rx);
               chk("share_ch_addr", int'(ch_rd_addr2), e2.ch);
            end
         end
      end
   end

   task automatic push_run(input int n);
      for (int k = 0; k < n; k++) begin
         q_rd.push_back('{rel: k + 1, addr: k});
         q_in.push_back('{rel: k + 3, addr: k});
      end
      q_done.push_back('{rel: n + 4, addr: n});
   endtask

   task automatic run_start(input int n);
      num_re = AW'(n);
      start  = 1'b1;
      t0     = cyc;
      step(1);
      start  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (q_done.size() != 0 && i < budget) begin
         step(1);
         i++;
      end
      if (q_done.size() != 0) chk("done_timeout", 0, 1);
      chk("reads_left", q_rd.size(), 0);
      chk("strobes_left", q_in.size(), 0);
      q_done.delete();
      q_rd.delete();
      q_in.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hold_rd[8];
      int hold_in[8];
      bit found;
      hold_rd = '{1, 2, 7, 8, 9, 10, 11, 12};
      hold_in = '{3, 4, 9, 10, 11, 12, 13, 14};

      // Reset values
      step(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rx_rd_en), 0);
      chk("rst_in_valid", int'(eq_in_valid), 0);
      chk("rst_re_count", int'(re_count), 0);
      chk("rst_rd_addr", int'(rx_rd_addr), 0);
      rst = 1'b0;
      step(2);

      // Nominal full PBCH
      push_run(432);
      run_start(432);
      chk("busy_after_start", int'(busy), 1);
      wait_done(600);
      step(3);
      chk("re_count_hold", int'(re_count), 432);
      chk("idle_busy", int'(busy), 0);

      // Hold during cycles 3..6
      for (int k = 0; k < 8; k++) begin
         q_rd.push_back('{rel: hold_rd[k], addr: k});
         q_in.push_back('{rel: hold_in[k], addr: k});
      end
      q_done.push_back('{rel: 16, addr: 8});
      run_start(8);
      step(2);
      hold = 1'b1;
      step(4);
      hold = 1'b0;
      wait_done(60);

      // Channel-estimate sharing on the second instance
      for (int k = 0; k < 8; k++) q_rd2.push_back('{rel: k + 1, rx: k, ch: k >> 2});
      num_re = AW'(8);
      start2 = 1'b1;
      t0     = cyc;
      step(1);
      start2 = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (done2) begin
            found = 1'b1;
            chk("share_done_cycle", cyc - t0, 12);
            chk("share_re_count", int'(re_count2), 8);
         end
      end
      if (!found) chk("share_done_timeout", 0, 1);
      chk("share_reads_left", q_rd2.size(), 0);
      q_rd2.delete();

      // Single RE
      push_run(1);
      run_start(1);
      wait_done(30);

      // Abort at cycle 100, restart at cycle 110
      for (int k = 0; k < 100; k++) q_rd.push_back('{rel: k + 1, addr: k});
      for (int k = 0; k < 98; k++) q_in.push_back('{rel: k + 3, addr: k});
      run_start(432);
      step(99);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      for (int i = 101; i < 110; i++) begin
         chk("abort_busy", int'(busy), 0);
         chk("abort_in_valid", int'(eq_in_valid), 0);
         chk("abort_re_count", int'(re_count), 0);
         step(1);
      end
      chk("abort_reads_left", q_rd.size(), 0);
      chk("abort_strobes_left", q_in.size(), 0);
      q_rd.delete();
      q_in.delete();
      push_run(432);
      run_start(432);
      wait_done(600);

      // num_re=0 runs a full PBCH; a start while busy is ignored
      push_run(432);
      run_start(0);
      step(49);
      num_re = AW'(5);
      start  = 1'b1;
      step(1);
      start  = 1'b0;
      wait_done(600);

      // Asynchronous reset mid-fetch
      push_run(432);
      run_start(432);
      step(49);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_rd_en", int'(rx_rd_en), 0);
      chk("arst_rd_addr", int'(rx_rd_addr), 0);
      chk("arst_in_valid", int'(eq_in_valid), 0);
      chk("arst_eq_rx_i", int'(eq_rx_i), 0);
      chk("arst_re_count", int'(re_count), 0);
      q_rd.delete();
      q_in.delete();
      q_done.delete();
      step(2);
      rst = 1'b0;
      step(2);
      stray = 1'b1;
      step(1);
      stray = 1'b0;
      step(2);
      chk("idle_stray_re_count", int'(re_count), 0);
      chk("idle_stray_busy", int'(busy), 0);
      chk("idle_stray_rd_en", int'(rx_rd_en), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
